// File: rtl/ifetch_pkg.sv
// Shared widths, fetch step and FIFO entry type for the instruction fetch unit.
package ifetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 8'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low address bits are never honoured.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Bus bundle between the fetch unit, the program ROM, decode and execute.
interface ifetch_if;
  import ifetch_pkg::*;

  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               fault;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fault
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc,
    input  fault
  );

endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry fetch FIFO of {pc, instr}; flush empties it and wins over push.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [PW:0]  wr_ptr_reg;
  logic [PW:0]  rd_ptr_reg;
  fetch_entry_t mem_reg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        mem_reg[gi] <= '0;
      else if (push && !flush && (wr_ptr_reg[PW-1:0] == PW'(gi)))
        mem_reg[gi] <= din;
    end
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                 (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign head  = mem_reg[rd_ptr_reg[PW-1:0]];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, ROM addressing, redirect/flush control, fetch FIFO to decode.
// Define IFETCH_BOUND_EN to halt fetch past PROG_LAST and raise the sticky fault flag.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter int                DEPTH     = 2,
  parameter logic [ADDR_W-1:0] PROG_LAST = 8'h4C
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.master bus
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              halted;
  logic              fetch_en;
  logic              pop;
  logic              full;
  logic              empty;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  assign pop        = !empty && bus.out_ready;
  assign fetch_en   = !bus.redirect_valid && (!full || pop) && !halted;
  assign push_entry = '{pc: pc_reg, instr: bus.rom_data};

  always_comb begin
    pc_next = pc_reg;
    if (bus.redirect_valid)
      pc_next = align_pc(bus.redirect_pc);
    else if (fetch_en)
      pc_next = pc_reg + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= RESET_PC;
    else        pc_reg <= pc_next;
  end

`ifdef IFETCH_BOUND_EN
  logic fault_reg;
  logic fault_next;

  assign halted = (pc_reg > PROG_LAST);

  // Only a redirect back inside the program clears the fault; otherwise it sticks.
  always_comb begin
    fault_next = fault_reg;
    if (bus.redirect_valid) begin
      if (align_pc(bus.redirect_pc) <= PROG_LAST) fault_next = 1'b0;
    end else if (halted) begin
      fault_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_reg <= 1'b0;
    else        fault_reg <= fault_next;
  end

  assign bus.fault = fault_reg;
`else
  logic unused_bound;

  assign halted       = 1'b0;
  assign bus.fault    = 1'b0;
  assign unused_bound = ^PROG_LAST;
`endif

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch_en),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (push_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.rom_addr  = pc_reg;
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? '0 : head.instr;
  assign bus.out_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected in-order stream per redirect/reset, checked on delivery.
// Build with IFETCH_BOUND_EN defined to exercise the program-bound fault path.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam logic [7:0] RESET_PC  = 8'h00;
  localparam logic [7:0] PROG_LAST = 8'h4C;
  localparam int         DEPTH     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_if bus();

  ifetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .PROG_LAST(PROG_LAST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] rom [64];
  assign bus.rom_data = rom[bus.rom_addr[7:2]];

  int total = 0;
  int bad = 0;
  fetch_entry_t exp_q[$];
  logic [7:0] model_next;
  logic [7:0] last_pc = 8'h00;
  logic [31:0] last_instr = 32'h0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic bit in_program(input logic [7:0] a);
`ifdef IFETCH_BOUND_EN
    return a <= PROG_LAST;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: from any start address the delivered stream is consecutive words.
  task automatic refill();
    while (exp_q.size() < 16 && in_program(model_next)) begin
      exp_q.push_back('{pc: model_next, instr: rom[model_next[7:2]]});
      model_next = model_next + 8'd4;
    end
  endtask

  task automatic restart(input logic [7:0] a);
    exp_q.delete();
    model_next = {a[7:2], 2'b00};
    refill();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic redirect_to(input logic [7:0] a);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = a;
    @(negedge clk);
    #1;
    restart(a);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
  endtask

  // Monitor: compare head against scoreboard front; pop on handshake.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got pc %h, no entry expected", bus.out_pc);
      end else begin
        check("out_pc", {32'h0, bus.out_pc}, {32'h0, exp_q[0].pc});
        check("out_instr", {8'h0, bus.out_instr}, {8'h0, exp_q[0].instr});
        if (bus.out_ready) begin
          last_pc = bus.out_pc;
          last_instr = bus.out_instr;
          void'(exp_q.pop_front());
        end
      end
    end else begin
      check("idle_pc", {32'h0, bus.out_pc}, 40'h0);
      check("idle_instr", {8'h0, bus.out_instr}, 40'h0);
    end
`ifndef IFETCH_BOUND_EN
    check("fault_tied", {39'h0, bus.fault}, 40'h0);
`endif
  end

  initial begin
    int r;
    bit seen;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0]  = 32'h00000000;
    rom[1]  = 32'h00450693;
    rom[2]  = 32'h00100713;
    rom[6]  = 32'h00068613;
    rom[7]  = 32'h00070793;
    rom[19] = 32'hfc1ff06f;

    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    restart(RESET_PC);
    #2;
    check("rst_valid", {39'h0, bus.out_valid}, 40'h0);
    check("rst_pc", {32'h0, bus.out_pc}, 40'h0);
    check("rst_instr", {8'h0, bus.out_instr}, 40'h0);
    check("rst_rom_addr", {32'h0, bus.rom_addr}, {32'h0, RESET_PC});
    check("rst_fault", {39'h0, bus.fault}, 40'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // First three words after release, one per cycle.
    @(negedge clk);
    check("first_pc0", {32'h0, bus.out_pc}, 40'h00);
    check("first_in0", {8'h0, bus.out_instr}, 40'h0);
    @(negedge clk);
    check("first_pc1", {32'h0, bus.out_pc}, 40'h04);
    check("first_in1", {8'h0, bus.out_instr}, {8'h0, 32'h00450693});
    @(negedge clk);
    check("first_pc2", {32'h0, bus.out_pc}, 40'h08);
    check("first_in2", {8'h0, bus.out_instr}, {8'h0, 32'h00100713});

    // Asynchronous reset with the FIFO occupied.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    restart(RESET_PC);
    #1;
    check("midrst_valid", {39'h0, bus.out_valid}, 40'h0);
    check("midrst_rom_addr", {32'h0, bus.rom_addr}, {32'h0, RESET_PC});
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Backpressure: fills to DEPTH, then PC freezes.
    repeat (5) cyc();
    @(negedge clk);
    check("bp_rom_addr", {32'h0, bus.rom_addr}, 40'h08);
    check("bp_valid", {39'h0, bus.out_valid}, 40'h1);
    check("bp_pc", {32'h0, bus.out_pc}, 40'h00);

    // Redirect while full; low target bits dropped.
    redirect_to(8'h1F);
    @(negedge clk);
    check("redir_valid", {39'h0, bus.out_valid}, 40'h0);
    check("redir_rom_addr", {32'h0, bus.rom_addr}, 40'h1C);
    @(negedge clk);
    check("redir_pc", {32'h0, bus.out_pc}, 40'h1C);
    check("redir_instr", {8'h0, bus.out_instr}, {8'h0, 32'h00070793});
    repeat (3) cyc();
    bus.out_ready = 1'b1;
    repeat (6) cyc();

`ifndef IFETCH_BOUND_EN
    redirect_to(8'hFC);
    @(negedge clk);
    check("wrap_gap", {39'h0, bus.out_valid}, 40'h0);
    @(negedge clk);
    check("wrap_pc0", {32'h0, bus.out_pc}, 40'hFC);
    @(negedge clk);
    check("wrap_pc1", {32'h0, bus.out_pc}, 40'h00);
    @(negedge clk);
    check("wrap_pc2", {32'h0, bus.out_pc}, 40'h04);
`else
    redirect_to(8'h00);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc();
      if (bus.fault === 1'b1) seen = 1'b1;
    end
    check("fault_set", {39'h0, seen}, 40'h1);
    repeat (4) cyc();
    @(negedge clk);
    check("drain_valid", {39'h0, bus.out_valid}, 40'h0);
    check("drain_all", 40'(exp_q.size()), 40'h0);
    check("last_pc", {32'h0, last_pc}, {32'h0, PROG_LAST});
    check("last_instr", {8'h0, last_instr}, {8'h0, 32'hfc1ff06f});
    redirect_to(8'h18);
    @(negedge clk);
    check("fault_clear", {39'h0, bus.fault}, 40'h0);
    @(negedge clk);
    check("resume_instr", {8'h0, bus.out_instr}, {8'h0, 32'h00068613});
`endif

    // Randomized traffic: backpressure, redirects, occasional reset.
    for (int n = 0; n < 1500; n++) begin
      cyc();
      r = $urandom_range(0, 999);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if (r < 5) begin
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        restart(RESET_PC);
      end else begin
        bus.out_ready = ($urandom_range(0, 9) < 7);
        bus.redirect_valid = ($urandom_range(0, 19) == 0);
`ifdef IFETCH_BOUND_EN
        bus.redirect_pc = 8'($urandom_range(0, 8'h5F));
`else
        bus.redirect_pc = 8'($urandom);
`endif
        if (bus.redirect_valid) begin
          @(negedge clk);
          #1 restart(bus.redirect_pc);
        end
      end
    end
    cyc();
    rst_n = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch initiator for the 8-bit-addressed, 32-bit-wide combinational program ROM.
- Drives the ROM address from an internal PC and captures each returned word with its PC into a small FIFO.
- Presents fetched instructions to decode over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from execute and flushes stale fetches.

Parameters:
- RESET_PC, 8'h00: PC value loaded at reset.
- DEPTH, 2: fetch FIFO entries; power of two, ≥ 2.
- PROG_LAST, 8'h4C: last valid instruction address. Used only when IFETCH_BOUND_EN is defined.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rom_addr  output  8  address to program ROM
- rom_data  input  32  word returned by ROM, same cycle, combinational
- out_valid  output  1  head FIFO entry is valid
- out_ready  input  1  decode accepts head entry
- out_instr  output  32  head instruction
- out_pc  output  8  PC of head instruction
- redirect_valid  input  1  execute requests PC change
- redirect_pc  input  8  redirect target
- fault  output  1  fetch-bound fault, sticky

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; FIFO empty; fault=0.
  - FIFO storage cleared to 0.
  - Outputs during reset: out_valid=0, out_instr=0, out_pc=0, rom_addr=RESET_PC.
- ROM interface: rom_addr = pc at all times (combinational from the pc register). rom_data is sampled in the same cycle.
- Fetch condition: fetch_en = !redirect_valid && (!full || pop) && !halted. halted exists only with IFETCH_BOUND_EN.
- On fetch_en:
  - Push {pc, rom_data}.
  - pc <= pc + 8'd4, modulo 256: 8'hFC wraps to 8'h00.
- Pop: pop = out_valid && out_ready.
- Output latency: a word fetched in cycle N is visible on out_* in cycle N+1 at the earliest.
- Output formatting:
  - out_valid = !empty.
  - out_instr and out_pc come from the FIFO head.
  - Both are forced to 0 while out_valid=0.
- Throughput: 1 instruction/cycle while out_ready=1. Push and pop in the same cycle when full are allowed, and occupancy is unchanged.
- Backpressure: with out_ready=0, the FIFO fills to DEPTH, then the PC freezes. out_* remain stable while out_valid=1 and out_ready=0.
- Redirect, redirect_valid=1 in cycle N:
  - Takes priority over fetch.
  - A pop in cycle N still counts as consumed.
  - At edge N: FIFO flushed, pc <= {redirect_pc[7:2], 2'b00}. The low two bits are silently dropped.
  - Cycle N+1: fetch at target; out_valid=0.
  - Cycle N+2: out_valid=1 with out_pc = target.
- Back-to-back redirects: the last one wins; nothing is fetched while redirect_valid is held high.
- Reset mid-operation: immediate return to the reset state. No partial entry survives.

Optional Feature:
- Macro: IFETCH_BOUND_EN.
- Defined:
  - When pc > PROG_LAST, no fetch occurs: halted=1 and fault=1.
  - fault is sticky until reset, or until a redirect to a target ≤ PROG_LAST. That redirect clears fault on the same edge that loads pc.
  - Entries already in the FIFO still drain normally.
- Not defined:
  - fault is tied to 0.
  - Fetch runs unbounded with PC wrap.
  - PROG_LAST is ignored.

Decomposition:
- Package ifetch_pkg holds:
  - ADDR_W=8, INSTR_W=32, PC_STEP=8'd4.
  - A fetch_entry_t struct {pc[7:0], instr[31:0]}.
- Sub-module ifetch_fifo:
  - Synchronous DEPTH-entry FIFO of fetch_entry_t.
  - Inputs: push, pop, flush. Outputs: full, empty, head.
  - flush has priority over push.
- The top-level block holds the pc register, fetch/redirect control and fault logic.

Test Plan:
- Reset release, out_ready=1, program ROM loaded:
  - cycle 1 after release: out_pc=8'h00, out_instr=32'h00000000.
  - next cycle: 8'h04 / 32'h00450693.
  - next cycle: 8'h08 / 32'h00100713.
  - One instruction per cycle thereafter.
- out_ready=0 for 5 cycles after the first valid:
  - FIFO holds 2 entries; rom_addr frozen at 8'h08.
  - out_pc stays 8'h00.
  - Releasing out_ready resumes in order 8'h00, 8'h04, 8'h08 with no gaps or duplicates.
- redirect_valid=1, redirect_pc=8'h1F while FIFO full:
  - next cycle out_valid=0 and rom_addr=8'h1C.
  - following cycle out_pc=8'h1C, out_instr=32'h00070793.
- Redirect to 8'hFC, out_ready=1:
  - sequence out_pc=8'hFC, then 8'h00, then 8'h04 (wrap).
- With IFETCH_BOUND_EN and PROG_LAST=8'h4C:
  - free-run: last delivered out_pc=8'h4C, out_instr=32'hfc1ff06f.
  - fault=1 once pc=8'h50; out_valid=0 after drain.
  - redirect to 8'h18 clears fault; delivery resumes with 32'h00068613.
- Assert rst_n=0 mid-stream with FIFO occupied:
  - out_valid=0 and rom_addr=RESET_PC asynchronously.
  - After release, sequence restarts at 8'h00.
